// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_sram_responder
//  Brief    : Single-port 32-bit data SRAM with a request/response handshake
//             for the CPU memory stage. A request is captured in IDLE, held
//             through optional wait states, and completed in RESP with a
//             one-cycle ready pulse. Byte-lane writes; reads are registered.
//  Options  : DSRAM_WAIT_STATE_EN - when defined, WAIT_CYCLES wait states are
//             inserted before each response; otherwise IDLE goes straight to
//             RESP and WAIT_CYCLES is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  // Captured request (word index, lane enables, write data)
  logic [ADDR_WIDTH-1:0] r_reqIdx;
  logic [3:0]            r_reqWen;
  logic [31:0]           r_reqWdata;

  // Storage array; deliberately has no reset
  logic [31:0]           r_mem [c_DEPTH];

  // Request seen by the commit logic: live inputs on the capture edge,
  // captured copy afterwards (covers the zero-wait path where capture and
  // commit happen on the same edge)
  logic                  w_inIdle;
  logic [ADDR_WIDTH-1:0] w_reqIdx;
  logic [3:0]            w_reqWen;
  logic [31:0]           w_reqWdata;
  logic                  w_isWrite;
  logic                  w_enterResp;

  // Address bits outside the word index are intentionally ignored
  logic                  w_unusedAddrBits;
  assign w_unusedAddrBits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  assign w_inIdle   = (r_state == IDLE);
  assign w_reqIdx   = w_inIdle ? addr[ADDR_WIDTH+1:2] : r_reqIdx;
  assign w_reqWen   = w_inIdle ? wen   : r_reqWen;
  assign w_reqWdata = w_inIdle ? wdata : r_reqWdata;
  assign w_isWrite  = |w_reqWen;
  // Gated by rst so a request in flight when reset hits never commits
  assign w_enterResp = rst && (w_nextState == RESP);

`ifdef DSRAM_WAIT_STATE_EN
  localparam bit       c_HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [3:0] r_count;

  // Wait-state counter: loaded on the edge entering WAIT, counts down to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 4'd0;
    end else if (w_inIdle && en && c_HAS_WAIT) begin
      r_count <= c_WAIT_LOAD;
    end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end
`else
  logic [3:0] w_unusedWaitCycles;
  assign w_unusedWaitCycles = 4'(WAIT_CYCLES);
`endif

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (en) begin
`ifdef DSRAM_WAIT_STATE_EN
          w_nextState = c_HAS_WAIT ? WAIT : RESP;
`else
          w_nextState = RESP;
`endif
        end
      end
      WAIT: begin
`ifdef DSRAM_WAIT_STATE_EN
        if (r_count == 4'd0) begin
          w_nextState = RESP;
        end
`else
        w_nextState = IDLE;
`endif
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the request on the edge it is accepted in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reqIdx   <= '0;
      r_reqWen   <= 4'd0;
      r_reqWdata <= 32'd0;
    end else if (w_inIdle && en) begin
      r_reqIdx   <= addr[ADDR_WIDTH+1:2];
      r_reqWen   <= wen;
      r_reqWdata <= wdata;
    end
  end

  // Read data register: updated only by a read response, held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'd0;
    end else if (w_enterResp && !w_isWrite) begin
      rdata <= r_mem[w_reqIdx];
    end
  end

  // Byte-lane write commit on the edge entering RESP
  always_ff @(posedge clk) begin
    if (w_enterResp && w_isWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (w_reqWen[b]) begin
          r_mem[w_reqIdx][8*b +: 8] <= w_reqWdata[8*b +: 8];
        end
      end
    end
  end

  assign ready = (r_state == RESP);
  assign busy  = rst && ((w_inIdle && en) || (r_state == WAIT));

endmodule
`default_nettype wire

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address bits (1024 x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response (range 0..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-low (asserted at 0).
REQ-005 SHALL have port en  input  1  meaning memory request from the CPU memory stage.
REQ-006 SHALL have port wen  input  4  meaning byte write enables; 4'b0000 = read, any other value = write.
REQ-007 SHALL have port addr  input  32  meaning byte address; word index = addr[ADDR_WIDTH+1:2].
REQ-008 SHALL have port wdata  input  32  meaning write data, byte-lane aligned.
REQ-009 SHALL have port rdata  output  32  meaning read data for the completed read.
REQ-010 SHALL have port ready  output  1  meaning one-cycle pulse that the captured request completed.
REQ-011 SHALL have port busy  output  1  meaning stall request to the hazard unit while a request is outstanding.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 In IDLE with en=1, SHALL capture addr, wen and wdata at the clock edge and go to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-014 In WAIT, SHALL load a counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to RESP when it reaches 0.
REQ-015 On the edge entering RESP, SHALL commit writes using only the enabled byte lanes, and SHALL register read data into rdata.
REQ-016 In RESP, SHALL drive ready=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-017 SHALL drive busy = (IDLE and en) or WAIT, combinationally.
REQ-018 SHALL complete a captured request even if en, addr or wdata change or drop during WAIT.
REQ-019 SHALL treat en=1 sampled in IDLE after RESP as a new request; the master deasserts en or presents the next request after ready.
REQ-020 SHALL hold rdata from one read until the next read response; a write SHALL leave rdata unchanged.
REQ-021 SHALL ignore address bits above ADDR_WIDTH+1 (aliasing); SHALL ignore addr[1:0] (alignment is checked upstream).
REQ-022 Read latency from en sampled to ready SHALL be WAIT_CYCLES+1 cycles.
REQ-023 Read-after-write to the same word SHALL return the newly written bytes.

Reset
REQ-024 SHALL, while rst=0, force state to IDLE, the counter to 0, the captured request to 0, rdata to 0, ready to 0 and busy to 0.
REQ-025 Reset asserted mid-request SHALL abort the request, and a pending write SHALL NOT be committed.
REQ-026 Memory array contents SHALL NOT be reset.

Configuration
REQ-027 Macro DSRAM_WAIT_STATE_EN: when defined, wait states per REQ-014 SHALL be used.
REQ-028 Without DSRAM_WAIT_STATE_EN, WAIT SHALL be removed and WAIT_CYCLES ignored: IDLE goes directly to RESP, latency is 1, and busy = IDLE and en.

Verification
REQ-029 Write wen=4'hF, addr=0x10, wdata=0xDEADBEEF, then read addr=0x10 -> rdata=0xDEADBEEF; ready 3 cycles after en with macro and WAIT_CYCLES=2, 1 cycle without.
REQ-030 Preload 0x11223344 at 0x20, write wen=4'b0010 wdata=0x0000AA00, then read -> 0x1122AA44.
REQ-031 Drop en and change addr one cycle into WAIT -> original request completes, ready pulses once, busy=0 in RESP.
REQ-032 Assert rst=0 during WAIT of a write to 0x30 (old value 0x0) -> state IDLE, rdata=0, busy=0; a later read of 0x30 returns 0x0.
REQ-033 Read addr=0x1004 with ADDR_WIDTH=10 -> returns the word at 0x004 (alias).
REQ-034 Two back-to-back reads of 0x0 and 0x4 -> two ready pulses separated by exactly one IDLE cycle; rdata holds the first value until the second response.
